mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 164 ++++++++++++++++
 tb/tb_mdu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers (32-cycle radix-2 datapath).
// Define MDU_FAST_MUL_EN to complete MULT/MULTU in a single combinational cycle.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        md_hi_we,
    input  logic        md_lo_we,
    input  logic [31:0] md_wdata,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operation context captured at start; the datapath works on magnitudes.
    typedef struct packed {
        logic        is_div;
        logic        neg_res;
        logic        neg_rem;
        logic        div_zero;
        logic [31:0] dvd_raw;
    } ctx_t;

    state_t      state, state_nxt;
    ctx_t        ctx;
    logic [4:0]  cnt;
    logic [31:0] acc_hi, acc_lo, opnd;

    logic        is_signed, s1_neg, s2_neg;
    logic [31:0] mag1, mag2;
    logic        start_ok, last_step, fast_go;

    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] res_hi, res_lo;

    assign is_signed = ~md_op[0];
    assign s1_neg    = is_signed & md_src1[31];
    assign s2_neg    = is_signed & md_src2[31];
    assign mag1      = s1_neg ? (~md_src1 + 32'd1) : md_src1;
    assign mag2      = s2_neg ? (~md_src2 + 32'd1) : md_src2;

    assign start_ok  = (state == IDLE) && md_start;
    assign last_step = (state == RUN) && (cnt == 5'd31);

`ifdef MDU_FAST_MUL_EN
    logic [63:0] fast_ext1, fast_ext2, fast_prod;
    // Low 64 bits of the sign/zero-extended product are correct for both MULT and MULTU.
    assign fast_ext1 = {{32{s1_neg | (is_signed & md_src1[31])}}, md_src1};
    assign fast_ext2 = {{32{s2_neg | (is_signed & md_src2[31])}}, md_src2};
    assign fast_prod = fast_ext1 * fast_ext2;
    assign fast_go   = start_ok && !md_op[1];
`else
    assign fast_go   = 1'b0;
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_sh   = {acc_hi, acc_lo[31]};
        div_diff = {1'b0, div_sh} - {2'b00, opnd};
        step_hi  = mul_sum[32:1];
        step_lo  = {mul_sum[0], acc_lo[31:1]};
        if (ctx.is_div) begin
            if (!div_diff[33]) begin
                step_hi = div_diff[31:0];
                step_lo = {acc_lo[30:0], 1'b1};
            end else begin
                step_hi = div_sh[31:0];
                step_lo = {acc_lo[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = ctx.neg_res ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
        quo_fix  = ctx.neg_res ? (~step_lo + 32'd1) : step_lo;
        rem_fix  = ctx.neg_rem ? (~step_hi + 32'd1) : step_hi;
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (ctx.is_div) begin
            if (ctx.div_zero) begin
                res_hi = ctx.dvd_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (md_start) state_nxt = fast_go ? DONE : RUN;
            RUN:  if (cnt == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            ctx    <= '0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            opnd   <= 32'd0;
        end else if (start_ok) begin
            cnt          <= 5'd0;
            ctx.is_div   <= md_op[1];
            ctx.neg_res  <= s1_neg ^ s2_neg;
            ctx.neg_rem  <= s1_neg;
            ctx.div_zero <= (md_src2 == 32'd0);
            ctx.dvd_raw  <= md_src1;
            acc_hi       <= 32'd0;
            // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
            acc_lo       <= md_op[1] ? mag1 : mag2;
            opnd         <= md_op[1] ? mag2 : mag1;
        end else if (state == RUN) begin
            cnt    <= cnt + 5'd1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Result writes win over a same-edge strobe; strobes are dropped while RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_hi <= 32'd0;
            md_lo <= 32'd0;
        end else if (last_step) begin
            md_hi <= res_hi;
            md_lo <= res_lo;
`ifdef MDU_FAST_MUL_EN
        end else if (fast_go) begin
            md_hi <= fast_prod[63:32];
            md_lo <= fast_prod[31:0];
`endif
        end else if (state != RUN) begin
            if (md_hi_we) md_hi <= md_wdata;
            if (md_lo_we) md_lo <= md_wdata;
        end
    end

    assign md_busy = (state == RUN);
    assign md_done = (state == DONE);

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: scoreboard of expected HI/LO, latency and strobe/reset checks.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_src1, md_src2;
    logic        md_hi_we, md_lo_we;
    logic [31:0] md_wdata;
    logic        md_busy, md_done;
    logic [31:0] md_hi, md_lo;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_op(md_op),
        .md_src1(md_src1), .md_src2(md_src2), .md_hi_we(md_hi_we),
        .md_lo_we(md_lo_we), .md_wdata(md_wdata), .md_busy(md_busy),
        .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, ra;
        logic [63:0]     r;
        case (op)
            2'b00: begin sa = $signed(a); sb = $signed(b); r = sa * sb; end
            2'b01: begin ua = a; ub = b; r = ua * ub; end
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    qa = $signed(a) / $signed(b);
                    ra = $signed(a) % $signed(b);
                    r = {ra, qa};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        return (op[1] || !FAST) ? 33 : 1;
    endfunction

    // Entered in cycle lat0 after the start edge; returns positioned in the done cycle.
    task automatic wait_done(input string tag, input int lat0, input int want);
        int lat;
        logic [63:0] e;
        lat = lat0;
        while (md_done !== 1'b1 && lat < 60) begin
            chk({tag, "_busy"}, 64'(md_busy), 64'd1);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(want));
        chk({tag, "_busy_at_done"}, 64'(md_busy), 64'd0);
        e = sb_q.pop_front();
        chk({tag, "_hi"}, 64'(md_hi), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(md_lo), 64'(e[31:0]));
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(model(op, a, b));
        md_op = op; md_src1 = a; md_src2 = b; md_start = 1'b1;
        tick();
        md_start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        wait_done(tag, 1, exp_lat(op));
        tick();
        chk({tag, "_done_pulse"}, 64'(md_done), 64'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0; md_start = 1'b0; md_op = 2'b00; md_src1 = '0; md_src2 = '0;
        md_hi_we = 1'b0; md_lo_we = 1'b0; md_wdata = '0;
        tick(); tick();
        chk("rst_hi", 64'(md_hi), 64'd0);
        chk("rst_lo", 64'(md_lo), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_0", 2'b11, 32'd100, 32'd0);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0000);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
            run_op("rand", op, a, b);
        end

        // Second start mid-operation must be dropped.
        start_op(2'b11, 32'd10, 32'd3);
        lat = 1;
        while (md_done !== 1'b1 && lat < 60) begin
            if (lat == 10) begin
                md_op = 2'b11; md_src1 = 32'd5; md_src2 = 32'd5; md_start = 1'b1;
            end else md_start = 1'b0;
            tick();
            lat++;
        end
        md_start = 1'b0;
        chk("ign_start_lat", 64'(lat), 64'd33);
        begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("ign_start_hi", 64'(md_hi), 64'(e[63:32]));
            chk("ign_start_lo", 64'(md_lo), 64'(e[31:0]));
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done === 1'b1 || md_busy === 1'b1) seen = 1'b1;
        end
        chk("ign_start_no_queue", 64'(seen), 64'd0);

        // MTHI/MTLO in IDLE, then MTLO ignored during RUN.
        md_hi_we = 1'b1; md_wdata = 32'h1234_5678;
        tick();
        md_hi_we = 1'b0;
        chk("mthi_idle", 64'(md_hi), 64'h1234_5678);
        md_lo_we = 1'b1; md_wdata = 32'h1111_1111;
        tick();
        md_lo_we = 1'b0;
        chk("mtlo_idle", 64'(md_lo), 64'h1111_1111);
        start_op(2'b01, 32'd6, 32'd7);
        md_lo_we = 1'b1; md_wdata = 32'hA5A5_A5A5;
        tick();
        md_lo_we = 1'b0;
        chk("mtlo_run_lo", 64'(md_lo), 64'h1111_1111);
        chk("mtlo_run_hi", 64'(md_hi), 64'h1234_5678);
        wait_done("mtlo_run_op", 2, exp_lat(2'b01));
        tick();

        // Strobe with start lands, result overwrites later.
        md_hi_we = 1'b1; md_wdata = 32'hDEAD_BEEF;
        start_op(2'b11, 32'd100, 32'd7);
        md_hi_we = 1'b0;
        chk("strobe_with_start", 64'(md_hi), 64'hDEAD_BEEF);
        wait_done("strobe_with_start_op", 1, 33);
        tick();

        // Strobe during DONE overrides the freshly written result.
        start_op(2'b01, 32'd3, 32'd5);
        wait_done("done_strobe_op", 1, exp_lat(2'b01));
        md_lo_we = 1'b1; md_wdata = 32'hCAFE_F00D;
        tick();
        md_lo_we = 1'b0;
        chk("done_strobe_lo", 64'(md_lo), 64'hCAFE_F00D);
        chk("done_strobe_hi", 64'(md_hi), 64'd0);
        chk("done_strobe_idle", 64'(md_done), 64'd0);

        // Reset in cycle 15 of a divide aborts without a result or done pulse.
        md_op = 2'b11; md_src1 = 32'hFFFF_FFFF; md_src2 = 32'd2; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(md_busy), 64'd0);
        chk("abort_done", 64'(md_done), 64'd0);
        chk("abort_hi", 64'(md_hi), 64'd0);
        chk("abort_lo", 64'(md_lo), 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_done === 1'b1 || md_busy === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_hi_held", 64'(md_hi), 64'd0);

        // MULTU aborted mid-run, then a clean restart.
        md_op = 2'b01; md_src1 = 32'hFFFF_FFFF; md_src2 = 32'd9; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_mul_busy", 64'(md_busy), 64'd0);
        chk("abort_mul_lo", 64'(md_lo), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("after_reset", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
